// File: rtl/lab3_mux_arbiter.sv
// Round-robin arbiter for the lab3 two-input mux select line.
// Inserts a dead cycle on every handoff and revokes a grant after MAX_HOLD cycles when the other side waits.
module lab3_mux_arbiter #(
    parameter int MAX_HOLD = 1000,
    parameter int CNT_W    = $clog2(MAX_HOLD)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       req,
    output logic [1:0]       gnt,
    output logic             ctrl,
    output logic             busy,
    output logic             preempt,
    output logic [CNT_W-1:0] hold_cnt
);

    typedef enum logic [1:0] {IDLE, GRANT0, GRANT1, SWITCH} state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_HOLD - 1);

    state_t           state_q, state_d;
    logic             last_q, last_d;
    logic             ctrl_q, ctrl_d;
    logic [1:0]       gnt_q, gnt_d;
    logic             busy_q, busy_d;
    logic             preempt_q, preempt_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             own;
    logic             pick;

    always_comb begin
        state_d   = state_q;
        last_d    = last_q;
        ctrl_d    = ctrl_q;
        preempt_d = 1'b0;
        cnt_d     = '0;
        own       = (state_q == GRANT1);
        pick      = 1'b0;

        case (state_q)
            IDLE: begin
                if (req != 2'b00) begin
                    // On a tie the requester that was not served last wins.
                    pick    = (req == 2'b11) ? ~last_q : req[1];
                    state_d = pick ? GRANT1 : GRANT0;
                    last_d  = pick;
                    ctrl_d  = pick;
                end
            end
            GRANT0, GRANT1: begin
                if (!req[own]) begin
                    if (req[~own]) begin
                        state_d = SWITCH;
                        ctrl_d  = ~own;
                    end else begin
                        state_d = IDLE;
                    end
                end else if (req[~own] && (cnt_q == CNT_MAX)) begin
                    state_d   = SWITCH;
                    ctrl_d    = ~own;
                    preempt_d = 1'b1;
                end else begin
                    cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
                end
            end
            SWITCH: begin
                // Owner was fixed on entry; late requests cannot change it.
                if (req[~last_q]) begin
                    state_d = last_q ? GRANT0 : GRANT1;
                    last_d  = ~last_q;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        gnt_d  = {state_d == GRANT1, state_d == GRANT0};
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            last_q    <= 1'b1;
            ctrl_q    <= 1'b0;
            gnt_q     <= 2'b00;
            busy_q    <= 1'b0;
            preempt_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            last_q    <= last_d;
            ctrl_q    <= ctrl_d;
            gnt_q     <= gnt_d;
            busy_q    <= busy_d;
            preempt_q <= preempt_d;
            cnt_q     <= cnt_d;
        end
    end

    assign gnt      = gnt_q;
    assign ctrl     = ctrl_q;
    assign busy     = busy_q;
    assign preempt  = preempt_q;
    assign hold_cnt = cnt_q;

endmodule

// File: tb/tb_lab3_mux_arbiter.sv
// Directed and randomized bench for lab3_mux_arbiter with MAX_HOLD = 4,
// checked against a request/owner model kept in the bench.
module tb_lab3_mux_arbiter;

    localparam int MH = 4;
    localparam int CW = 2;

    logic          clk = 1'b0;
    logic          reset_n;
    logic [1:0]    req;
    logic [1:0]    gnt;
    logic          ctrl;
    logic          busy;
    logic          preempt;
    logic [CW-1:0] hold_cnt;

    int checks = 0;
    int errors = 0;

    // Model: current owner (-1 none), pending owner in the dead slot (-1 none)
    int m_owner, m_sw, m_cnt, m_last, m_ctrl, m_pre;
    logic [1:0] p_gnt;
    logic       p_ctrl;
    int         npre;

    lab3_mux_arbiter #(.MAX_HOLD(MH), .CNT_W(CW)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .req      (req),
        .gnt      (gnt),
        .ctrl     (ctrl),
        .busy     (busy),
        .preempt  (preempt),
        .hold_cnt (hold_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_owner = -1;
        m_sw    = -1;
        m_cnt   = 0;
        m_last  = 1;
        m_ctrl  = 0;
        m_pre   = 0;
        p_gnt   = 2'b00;
        p_ctrl  = 1'b0;
    endtask

    task automatic model_step(input logic [1:0] r);
        int k, o, p;
        m_pre = 0;
        if (m_sw >= 0) begin
            if (r[m_sw]) begin
                m_owner = m_sw;
                m_last  = m_sw;
                m_cnt   = 0;
            end
            m_sw = -1;
        end else if (m_owner >= 0) begin
            k = m_owner;
            o = 1 - k;
            if (!r[k]) begin
                m_owner = -1;
                if (r[o]) begin
                    m_sw   = o;
                    m_ctrl = o;
                end
            end else if (r[o] && m_cnt == MH - 1) begin
                m_owner = -1;
                m_sw    = o;
                m_ctrl  = o;
                m_pre   = 1;
            end else if (m_cnt < MH - 1) begin
                m_cnt++;
            end
        end else if (r != 2'b00) begin
            p = (r == 2'b11) ? 1 - m_last : (r[1] ? 1 : 0);
            m_owner = p;
            m_last  = p;
            m_ctrl  = p;
            m_cnt   = 0;
        end
    endtask

    task automatic check_model();
        logic [1:0] eg;
        eg = (m_owner < 0) ? 2'b00 : ((m_owner == 1) ? 2'b10 : 2'b01);
        chk("gnt", gnt, eg);
        chk("ctrl", ctrl, m_ctrl);
        chk("busy", busy, (m_owner >= 0 || m_sw >= 0) ? 1 : 0);
        chk("preempt", preempt, m_pre);
        if (m_owner >= 0) chk("hold_cnt", hold_cnt, m_cnt);
        if (p_gnt != 2'b00 && gnt != 2'b00) chk("ctrl_stable", ctrl, p_ctrl);
        p_gnt  = gnt;
        p_ctrl = ctrl;
    endtask

    task automatic tick();
        @(posedge clk);
        model_step(req);
        #1;
        check_model();
    endtask

    task automatic reset_vals(input string tag);
        chk({tag, "_gnt"}, gnt, 2'b00);
        chk({tag, "_ctrl"}, ctrl, 1'b0);
        chk({tag, "_busy"}, busy, 1'b0);
        chk({tag, "_preempt"}, preempt, 1'b0);
        chk({tag, "_hold_cnt"}, hold_cnt, 0);
    endtask

    initial begin
        // Reset with both requests high
        reset_n = 1'b0;
        req     = 2'b11;
        repeat (3) @(posedge clk);
        #1;
        reset_vals("rst");
        model_reset();
        reset_n = 1'b1;
        tick();
        chk("first_gnt", gnt, 2'b01);

        // Single requester, counter saturation
        req = 2'b00;
        tick();
        req = 2'b10;
        repeat (10) begin
            tick();
            chk("single_gnt", gnt, 2'b10);
            chk("single_ctrl", ctrl, 1'b1);
            chk("single_preempt", preempt, 1'b0);
        end
        chk("single_sat", hold_cnt, 3);
        req = 2'b00;
        tick();
        chk("single_idle_busy", busy, 1'b0);

        // Timeout rotation
        req  = 2'b11;
        npre = 0;
        repeat (20) begin
            tick();
            if (preempt === 1'b1) npre++;
        end
        chk("rotation_preempts", npre, 4);

        // Voluntary handoff
        req = 2'b00;
        tick();
        req = 2'b01;
        tick();
        chk("vol_gnt0", gnt, 2'b01);
        req = 2'b10;
        tick();
        chk("vol_dead_gnt", gnt, 2'b00);
        chk("vol_dead_ctrl", ctrl, 1'b1);
        chk("vol_dead_preempt", preempt, 1'b0);
        tick();
        chk("vol_new_gnt", gnt, 2'b10);

        // Abandon during the dead slot
        req = 2'b00;
        tick();
        req = 2'b01;
        tick();
        req = 2'b10;
        tick();
        req = 2'b00;
        tick();
        chk("abandon_gnt", gnt, 2'b00);
        chk("abandon_busy", busy, 1'b0);
        chk("abandon_ctrl", ctrl, 1'b1);

        // Asynchronous reset in the middle of a grant
        req = 2'b10;
        repeat (3) tick();
        chk("mid_hold_cnt", hold_cnt, 2);
        #3;
        reset_n = 1'b0;
        #1;
        reset_vals("async");
        model_reset();
        req = 2'b11;
        #2;
        reset_n = 1'b1;
        tick();
        chk("post_reset_gnt", gnt, 2'b01);

        // Randomized request segments
        repeat (80) begin
            req = 2'($urandom_range(0, 3));
            repeat ($urandom_range(1, 7)) tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
